// File: rtl/wb_data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module : wb_data_mem_bridge
// Brief  : Core data-memory port to single Wishbone classic transactions.
// Rev    : 1.0
// ============================================================================
module wb_data_mem_bridge #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  input  logic [DATA_WIDTH-1:0]   raddr_i,
  input  logic [DATA_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wmask_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [DATA_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    ack_i,
  input  logic                    err_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic              w_we;
  logic              w_timeout;
  logic [DATA_WIDTH-1:0] w_addr;

  assign w_we      = |wmask_i;
  assign w_addr    = w_we ? waddr_i : raddr_i;
  // A zero timeout disables the bound entirely; the counter simply wraps.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_count == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      rdata_o <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      addr_o  <= '0;
      dat_o   <= '0;
      sel_o   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          if (req_i) begin
            we_o    <= w_we;
            addr_o  <= {w_addr[DATA_WIDTH-1:2], 2'b00};
            dat_o   <= wdata_i;
            sel_o   <= w_we ? wmask_i : '1;
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            r_count <= '0;
            r_state <= BUS;
          end
        end
        BUS: begin
          r_count <= r_count + CNT_W'(1);
          if (ack_i) begin
            if (!we_o) rdata_o <= dat_i;
            err_o   <= 1'b0;
            done_o  <= 1'b1;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            r_state <= RESP;
          end else if (err_i || w_timeout) begin
            if (!we_o) rdata_o <= ERR_RDATA;
            err_o   <= 1'b1;
            done_o  <= 1'b1;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            r_state <= RESP;
          end
        end
        RESP: begin
          done_o  <= 1'b0;
          err_o   <= 1'b0;
          r_state <= HOLD;
        end
        HOLD: begin
          // A request still held after completion must not start a new cycle.
          if (!req_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_data_mem_bridge
// Brief  : Directed self-checking bench for wb_data_mem_bridge.
// Rev    : 1.0
// ============================================================================
module tb_wb_data_mem_bridge;

  localparam logic [31:0] c_err_rdata = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] raddr_i = '0;
  logic [31:0] waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wmask_i = '0;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;

  int tests = 0;
  int fails = 0;

  wb_data_mem_bridge #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA     (c_err_rdata)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_i),
    .raddr_i(raddr_i),
    .waddr_i(waddr_i),
    .wdata_i(wdata_i),
    .wmask_i(wmask_i),
    .rdata_o(rdata_o),
    .done_o (done_o),
    .err_o  (err_o),
    .cyc_o  (cyc_o),
    .stb_o  (stb_o),
    .we_o   (we_o),
    .addr_o (addr_o),
    .dat_o  (dat_o),
    .sel_o  (sel_o),
    .dat_i  (dat_i),
    .ack_i  (ack_i),
    .err_i  (err_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    int ncyc;
    int ndone;

    // Reset state
    tick(); tick();
    check("rst_cyc", 32'(cyc_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_addr", addr_o, 32'h0);
    rst_n = 1'b1;
    tick();

    // Case 1: read, ack two cycles after cyc_o
    raddr_i = 32'h1004; waddr_i = 32'h5678; wmask_i = 4'h0; req_i = 1'b1;
    tick();
    check("rd_cyc", 32'(cyc_o), 32'd1);
    check("rd_stb", 32'(stb_o), 32'd1);
    check("rd_addr", addr_o, 32'h1004);
    check("rd_sel", 32'(sel_o), 32'hF);
    check("rd_we", 32'(we_o), 32'd0);
    tick();
    check("rd_wait_done", 32'(done_o), 32'd0);
    ack_i = 1'b1; dat_i = 32'hCAFEF00D;
    tick();
    check("rd_done", 32'(done_o), 32'd1);
    check("rd_rdata", rdata_o, 32'hCAFEF00D);
    check("rd_err", 32'(err_o), 32'd0);
    check("rd_cyc_rel", 32'(cyc_o), 32'd0);
    ack_i = 1'b0; req_i = 1'b0;
    tick();
    check("rd_done_pulse", 32'(done_o), 32'd0);
    tick(); tick();

    // Case 2: write, immediate ack
    waddr_i = 32'h2003; raddr_i = 32'h9999; wdata_i = 32'h11223344; wmask_i = 4'b0011; req_i = 1'b1;
    tick();
    check("wr_addr", addr_o, 32'h2000);
    check("wr_sel", 32'(sel_o), 32'h3);
    check("wr_we", 32'(we_o), 32'd1);
    check("wr_dat", dat_o, 32'h11223344);
    ack_i = 1'b1;
    tick();
    check("wr_done", 32'(done_o), 32'd1);
    check("wr_rdata_kept", rdata_o, 32'hCAFEF00D);
    ack_i = 1'b0;

    // Case 3: request held after done never reissues
    ncyc = 0; ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cyc_o) ncyc++;
      if (done_o) ndone++;
    end
    check("held_cyc", 32'(ncyc), 32'd0);
    check("held_done", 32'(ndone), 32'd0);
    req_i = 1'b0;
    tick();
    raddr_i = 32'h3008; wmask_i = 4'h0; req_i = 1'b1;
    tick();
    check("reissue_cyc", 32'(cyc_o), 32'd1);
    check("reissue_addr", addr_o, 32'h3008);
    ack_i = 1'b1; err_i = 1'b1; dat_i = 32'h55AA55AA;
    tick();
    check("ackerr_done", 32'(done_o), 32'd1);
    check("ackerr_err", 32'(err_o), 32'd0);
    check("ackerr_rdata", rdata_o, 32'h55AA55AA);
    ack_i = 1'b0; err_i = 1'b0; req_i = 1'b0;
    tick(); tick();

    // Case 4: timeout after 8 cycles of cyc_o
    raddr_i = 32'h4000; wmask_i = 4'h0; req_i = 1'b1;
    tick();
    ncyc = 0;
    while (cyc_o && ncyc < 30) begin
      ncyc++;
      tick();
    end
    check("to_cycles", 32'(ncyc), 32'd8);
    check("to_done", 32'(done_o), 32'd1);
    check("to_err", 32'(err_o), 32'd1);
    check("to_rdata", rdata_o, c_err_rdata);
    req_i = 1'b0;
    tick();
    check("to_err_cleared", 32'(err_o), 32'd0);
    tick();

    // Bus error on a write: err flagged, read data untouched
    waddr_i = 32'h6000; wmask_i = 4'hF; req_i = 1'b1;
    tick();
    err_i = 1'b1;
    tick();
    check("werr_done", 32'(done_o), 32'd1);
    check("werr_err", 32'(err_o), 32'd1);
    check("werr_rdata", rdata_o, c_err_rdata);
    err_i = 1'b0; req_i = 1'b0;
    tick(); tick();

    // Case 5: reset while the bus cycle is open
    raddr_i = 32'h1004; wmask_i = 4'h0; req_i = 1'b1;
    tick();
    tick();
    check("mid_cyc_pre", 32'(cyc_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", 32'(cyc_o), 32'd0);
    check("mid_rst_stb", 32'(stb_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_rdata", rdata_o, 32'h0);
    req_i = 1'b0;
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done_o) ndone++;
    end
    check("post_rst_done", 32'(ndone), 32'd0);
    req_i = 1'b1;
    tick();
    check("post_cyc", 32'(cyc_o), 32'd1);
    check("post_addr", addr_o, 32'h1004);
    tick();
    ack_i = 1'b1; dat_i = 32'hCAFEF00D;
    tick();
    check("post_done", 32'(done_o), 32'd1);
    check("post_rdata", rdata_o, 32'hCAFEF00D);
    ack_i = 1'b0; req_i = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
